// File: rtl/ddr3_avalon_arbiter.sv
// Two-master Avalon-MM burst arbiter (display read master / camera write master) onto one DDR3 slave port.
// Optional burst statistics outputs are built when ARB_STATS_EN is defined.
module ddr3_avalon_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 128,
  parameter int BE_W         = 16,
  parameter int BURST_W      = 10,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  wr_address,
  input  logic               wr_write,
  input  logic [DATA_W-1:0]  wr_writedata,
  input  logic [BE_W-1:0]    wr_byteenable,
  input  logic [BURST_W-1:0] wr_burstcount,
  output logic               wr_waitrequest,
  input  logic [ADDR_W-1:0]  rd_address,
  input  logic               rd_read,
  input  logic [BE_W-1:0]    rd_byteenable,
  input  logic [BURST_W-1:0] rd_burstcount,
  output logic               rd_waitrequest,
  output logic [DATA_W-1:0]  rd_readdata,
  output logic               rd_readdatavalid,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic [BE_W-1:0]    avm_byteenable,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [1:0]         grant
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        stat_rd_bursts,
  output logic [15:0]        stat_wr_bursts
`endif
);

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_DATA} state_t;

  localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

  state_t             state, state_nxt;
  logic [BURST_W-1:0] beats_left, beats_left_nxt;
  logic               wr_first, wr_first_nxt;
  logic [7:0]         starve_cnt;
  logic [BURST_W-1:0] rd_bc_eff, wr_bc_eff;
  logic               rd_accept, wr_accept, wr_starved;

  assign rd_bc_eff  = (rd_burstcount == '0) ? ONE : rd_burstcount;
  assign wr_bc_eff  = (wr_burstcount == '0) ? ONE : wr_burstcount;
  assign rd_accept  = rd_read  & ~avm_waitrequest;
  assign wr_accept  = wr_write & ~avm_waitrequest;
  assign wr_starved = int'(starve_cnt) >= STARVE_LIMIT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beats_left <= '0;
      wr_first   <= 1'b1;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      wr_first   <= wr_first_nxt;
      if (state == IDLE && state_nxt == WR_DATA)
        starve_cnt <= '0;
      else if (wr_write && !grant[0] && starve_cnt != '1)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // wr_first marks the first accepted write beat, which loads the remaining-beat count.
  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    wr_first_nxt   = wr_first;
    case (state)
      IDLE: begin
        wr_first_nxt = 1'b1;
        if (rd_read && (!wr_write || !wr_starved))
          state_nxt = RD_CMD;
        else if (wr_write)
          state_nxt = WR_DATA;
      end
      RD_CMD: begin
        if (rd_accept) begin
          beats_left_nxt = rd_bc_eff;
          state_nxt      = RD_DATA;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          beats_left_nxt = beats_left - ONE;
          if (beats_left <= ONE)
            state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        if (wr_accept) begin
          if (wr_first) begin
            wr_first_nxt   = 1'b0;
            beats_left_nxt = wr_bc_eff - ONE;
            if (wr_bc_eff == ONE)
              state_nxt = IDLE;
          end else begin
            beats_left_nxt = beats_left - ONE;
            if (beats_left <= ONE)
              state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_address      = '0;
    avm_read         = 1'b0;
    avm_write        = 1'b0;
    avm_writedata    = '0;
    avm_byteenable   = '0;
    avm_burstcount   = '0;
    wr_waitrequest   = 1'b1;
    rd_waitrequest   = 1'b1;
    rd_readdatavalid = 1'b0;
    grant            = 2'b00;
    case (state)
      RD_CMD: begin
        avm_address    = rd_address;
        avm_read       = rd_read;
        avm_byteenable = rd_byteenable;
        avm_burstcount = rd_burstcount;
        rd_waitrequest = avm_waitrequest;
        grant          = 2'b10;
      end
      RD_DATA: begin
        rd_readdatavalid = avm_readdatavalid;
        grant            = 2'b10;
      end
      WR_DATA: begin
        avm_address    = wr_address;
        avm_write      = wr_write;
        avm_writedata  = wr_writedata;
        avm_byteenable = wr_byteenable;
        avm_burstcount = wr_burstcount;
        wr_waitrequest = avm_waitrequest;
        grant          = 2'b01;
      end
      default: ;
    endcase
  end

  assign rd_readdata = avm_readdata;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rd_bursts <= '0;
      stat_wr_bursts <= '0;
    end else begin
      if (state != RD_CMD && state_nxt == RD_CMD && stat_rd_bursts != '1)
        stat_rd_bursts <= stat_rd_bursts + 16'd1;
      if (state != WR_DATA && state_nxt == WR_DATA && stat_wr_bursts != '1)
        stat_wr_bursts <= stat_wr_bursts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_avalon_arbiter.sv
// Scoreboard bench for ddr3_avalon_arbiter: directed bursts, contention, stray data and mid-burst reset.
module tb_ddr3_avalon_arbiter;

  logic         clk;
  logic         rst_n;
  logic [31:0]  wr_address;
  logic         wr_write;
  logic [127:0] wr_writedata;
  logic [15:0]  wr_byteenable;
  logic [9:0]   wr_burstcount;
  logic         wr_waitrequest;
  logic [31:0]  rd_address;
  logic         rd_read;
  logic [15:0]  rd_byteenable;
  logic [9:0]   rd_burstcount;
  logic         rd_waitrequest;
  logic [127:0] rd_readdata;
  logic         rd_readdatavalid;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [9:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [127:0] avm_readdata;
  logic         avm_readdatavalid;
  logic [1:0]   grant;
`ifdef ARB_STATS_EN
  logic [15:0]  stat_rd_bursts;
  logic [15:0]  stat_wr_bursts;
`endif

  ddr3_avalon_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_burstcount(wr_burstcount), .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address), .rd_read(rd_read), .rd_byteenable(rd_byteenable),
    .rd_burstcount(rd_burstcount), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .grant(grant)
`ifdef ARB_STATS_EN
    , .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = read command accept, 1 = write beat accept, 2 = returned read beat
  typedef struct {
    logic [1:0]   kind;
    logic [31:0]  addr;
    logic [9:0]   bc;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  function automatic logic [127:0] pat(input int s);
    return {32'(s), 32'(s) ^ 32'hDEADBEEF, ~32'(s), 32'(s) * 32'd3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [31:0] addr,
                          input logic [9:0] bc, input logic [127:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.bc   = bc;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [31:0] addr,
                          input logic [9:0] bc, input logic [127:0] data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected kind=%0d got addr=%0h data=%0h required none", kind, addr, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.addr != addr || e.bc != bc || e.data != data) begin
        failures++;
        $display("FAIL sb_event got kind=%0d addr=%0h bc=%0d data=%0h required kind=%0d addr=%0h bc=%0d data=%0h",
                 kind, addr, bc, data, e.kind, e.addr, e.bc, e.data);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) sb_check(2'd0, avm_address, avm_burstcount, '0);
      if (avm_write && !avm_waitrequest) sb_check(2'd1, avm_address, avm_burstcount, avm_writedata);
      if (rd_readdatavalid) sb_check(2'd2, '0, '0, rd_readdata);
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input int bc, input int waits, input int lat);
    int beats;
    beats = (bc == 0) ? 1 : bc;
    push_exp(2'd0, addr, 10'(bc), '0);
    rd_address = addr; rd_burstcount = 10'(bc); rd_byteenable = '1; rd_read = 1'b1;
    avm_waitrequest = (waits > 0);
    tick();
    @(negedge clk);
    chk("rd_grant", 32'(grant), 2);
    chk("rd_wr_wait", 32'(wr_waitrequest), 1);
    for (int w = 0; w < waits; w++) begin
      if (w > 0) @(negedge clk);
      chk("rd_stall", 32'(rd_waitrequest), 1);
      tick();
    end
    if (waits > 0) begin
      avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    chk("rd_pass", 32'(rd_waitrequest), 0);
    tick();
    rd_read = 1'b0;
    for (int l = 0; l < lat; l++) begin
      @(negedge clk);
      chk("rd_data_grant", 32'(grant), 2);
      tick();
    end
    for (int i = 0; i < beats; i++) begin
      avm_readdata = pat(200 + i); avm_readdatavalid = 1'b1;
      push_exp(2'd2, '0, '0, pat(200 + i));
      tick();
    end
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("rd_release", 32'(grant), 0);
    #2;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int bc, input int stray_at);
    int beats;
    beats = (bc == 0) ? 1 : bc;
    for (int k = 0; k < beats; k++) push_exp(2'd1, addr, 10'(bc), pat(100 + k));
    wr_address = addr; wr_burstcount = 10'(bc); wr_byteenable = 16'h5A5A;
    wr_writedata = pat(100); wr_write = 1'b1; avm_waitrequest = 1'b0;
    tick();
    for (int k = 0; k < beats; k++) begin
      wr_writedata = pat(100 + k);
      if (k == stray_at) begin
        avm_waitrequest = 1'b1; avm_readdatavalid = 1'b1;
        @(negedge clk);
        chk("wr_stall", 32'(wr_waitrequest), 1);
        chk("stray_wr_rdv", 32'(rd_readdatavalid), 0);
        chk("stray_wr_beats", 32'(dut.beats_left), 32'(beats - k));
        tick();
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      end
      @(negedge clk);
      chk("wr_grant", 32'(grant), 1);
      chk("wr_rd_wait", 32'(rd_waitrequest), 1);
      if (k == 0) chk("wr_be", 32'(avm_byteenable), 32'h5A5A);
      tick();
    end
    wr_write = 1'b0;
    @(negedge clk);
    chk("wr_release", 32'(grant), 0);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    fork
      monitor();
    join_none

    // Reset with every request active: nothing may leak through.
    rst_n = 1'b0;
    wr_address = '1; wr_write = 1'b1; wr_writedata = '1; wr_byteenable = '1; wr_burstcount = 10'd5;
    rd_address = '1; rd_read = 1'b1; rd_byteenable = '1; rd_burstcount = 10'd5;
    avm_waitrequest = 1'b0; avm_readdata = '1; avm_readdatavalid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_avm_read", 32'(avm_read), 0);
    chk("rst_avm_write", 32'(avm_write), 0);
    chk("rst_avm_addr", avm_address, 0);
    chk("rst_avm_bc", 32'(avm_burstcount), 0);
    chk("rst_avm_be", 32'(avm_byteenable), 0);
    chk("rst_avm_wdata", 32'(|avm_writedata), 0);
    chk("rst_wr_wait", 32'(wr_waitrequest), 1);
    chk("rst_rd_wait", 32'(rd_waitrequest), 1);
    chk("rst_rdv", 32'(rd_readdatavalid), 0);
    chk("rst_starve", 32'(dut.starve_cnt), 0);
    chk("rst_beats", 32'(dut.beats_left), 0);
`ifdef ARB_STATS_EN
    chk("rst_stat_rd", 32'(stat_rd_bursts), 0);
    chk("rst_stat_wr", 32'(stat_wr_bursts), 0);
`endif
    #2;
    wr_write = 1'b0; rd_read = 1'b0; avm_readdatavalid = 1'b0;
    wr_address = '0; rd_address = '0; wr_writedata = '0; avm_readdata = '0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    #2;

    read_burst(32'h308DDC00, 16, 2, 2);
    write_burst(32'h1000_0000, 16, -1);
    write_burst(32'h1000_0400, 0, -1);

    // Stray returned data while idle.
    avm_readdatavalid = 1'b1;
    @(negedge clk);
    chk("stray_idle_rdv", 32'(rd_readdatavalid), 0);
    chk("stray_idle_beats", 32'(dut.beats_left), 0);
    #2;
    avm_readdatavalid = 1'b0;

    write_burst(32'h1000_0800, 4, 1);

    // A request that drops before the IDLE edge is never granted.
    tick();
    rd_read = 1'b1; wr_write = 1'b1;
    #2;
    rd_read = 1'b0; wr_write = 1'b0;
    tick();
    @(negedge clk);
    chk("pulse_nogrant", 32'(grant), 0);
    #2;

    // Contention: 6-cycle read bursts, starve_cnt reaches 66 at the 12th arbitration.
    rd_address = 32'h308DDC40; rd_burstcount = 10'd4; rd_read = 1'b1;
    wr_address = 32'h2000_0000; wr_burstcount = 10'd4; wr_writedata = pat(300); wr_write = 1'b1;
    avm_waitrequest = 1'b0;
    for (int g = 0; g < 11; g++) begin
      push_exp(2'd0, 32'h308DDC40, 10'd4, '0);
      tick();
      @(negedge clk);
      chk("ct_rd_grant", 32'(grant), 2);
      chk("ct_starve", 32'(dut.starve_cnt), 32'(6 * g + 1));
      tick();
      for (int b = 0; b < 4; b++) begin
        avm_readdata = pat(400 + b); avm_readdatavalid = 1'b1;
        push_exp(2'd2, '0, '0, pat(400 + b));
        tick();
      end
      avm_readdatavalid = 1'b0;
    end
    for (int k = 0; k < 4; k++) push_exp(2'd1, 32'h2000_0000, 10'd4, pat(300));
    @(negedge clk);
    chk("ct_starve_peak", 32'(dut.starve_cnt), 66);
    tick();
    @(negedge clk);
    chk("ct_wr_grant", 32'(grant), 1);
    chk("ct_starve_clr", 32'(dut.starve_cnt), 0);
    repeat (4) tick();
    rd_read = 1'b0; wr_write = 1'b0;
    @(negedge clk);
    chk("ct_release", 32'(grant), 0);
    #2;

    // Reset after beat 5 of a 16-beat read; the remaining beats must vanish.
    push_exp(2'd0, 32'h308DDC00, 10'd16, '0);
    rd_address = 32'h308DDC00; rd_burstcount = 10'd16; rd_read = 1'b1;
    tick();
    tick();
    rd_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      avm_readdata = pat(500 + i); avm_readdatavalid = 1'b1;
      push_exp(2'd2, '0, '0, pat(500 + i));
      tick();
    end
    avm_readdatavalid = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_rd_wait", 32'(rd_waitrequest), 1);
    chk("mid_rst_beats", 32'(dut.beats_left), 0);
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      avm_readdata = pat(505 + i); avm_readdatavalid = 1'b1;
      @(negedge clk);
      chk("drop_rdv", 32'(rd_readdatavalid), 0);
      tick();
    end
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    #2;

    // Three reads and two writes since the last reset.
    read_burst(32'h0000_0040, 1, 0, 1);
    read_burst(32'h0000_0080, 0, 1, 0);
    read_burst(32'h0000_00C0, 2, 0, 0);
    write_burst(32'h0000_0100, 1, -1);
    write_burst(32'h0000_0140, 0, -1);
`ifdef ARB_STATS_EN
    chk("stat_rd", 32'(stat_rd_bursts), 3);
    chk("stat_wr", 32'(stat_wr_bursts), 2);
`endif

    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_avalon_arbiter.md
# ddr3_avalon_arbiter

Two-master Avalon-MM burst arbiter that shares the single DDR3 Avalon-MM slave port between the camera-side write master and the display-side read master. Each grant covers one whole burst: write beats for a write master, command plus all returned read beats for a read master. The display read master normally has priority; a starvation limit guarantees the write master is served. Sits between the two DDR3 masters and the HPS/DDR3 controller port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 128, data width
- BE_W, 16, byteenable width
- BURST_W, 10, burstcount width
- STARVE_LIMIT, 64, cycles a pending write may wait before it takes priority over reads
- clk  in  1  system clock (50 MHz); single clock domain
- rst_n  in  1  reset; synchronous, active-low
- wr_address / wr_write / wr_writedata / wr_byteenable / wr_burstcount  in  ADDR_W/1/DATA_W/BE_W/BURST_W  write master command
- wr_waitrequest  out  1  stall to write master
- rd_address / rd_read / rd_byteenable / rd_burstcount  in  ADDR_W/1/BE_W/BURST_W  read master command
- rd_waitrequest  out  1  stall to read master
- rd_readdata  out  DATA_W  returned data (passthrough of avm_readdata)
- rd_readdatavalid  out  1  returned-data strobe
- avm_address / avm_read / avm_write / avm_writedata / avm_byteenable / avm_burstcount  out  ADDR_W/1/1/DATA_W/BE_W/BURST_W  slave-side command
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  slave read data
- avm_readdatavalid  in  1  slave read-data strobe
- grant  out  2  one-hot current owner: bit0 write, bit1 read; 00 when idle

## Operation
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA. Next state is registered. Slave-side mux is combinational from the state.
- IDLE:
  - avm_read = avm_write = 0.
  - All avm_* command buses are 0.
  - Both master waitrequests are 1.
- Arbitration in IDLE:
  - Only rd_read → RD_CMD.
  - Only wr_write → WR_DATA.
  - Both asserted → RD_CMD, unless starve_cnt ≥ STARVE_LIMIT, then → WR_DATA.
- RD_CMD:
  - avm_* is driven from rd_*.
  - rd_waitrequest = avm_waitrequest. wr_waitrequest = 1.
  - On accept (avm_read & ~avm_waitrequest): latch beats_left = rd_burstcount and go to RD_DATA.
- RD_DATA:
  - avm_read = 0.
  - rd_readdatavalid = avm_readdatavalid.
  - Each valid beat decrements beats_left. The beat that takes it from 1 to 0 → IDLE.
- WR_DATA:
  - avm_* is driven from wr_*.
  - wr_waitrequest = avm_waitrequest. rd_waitrequest = 1.
  - The first accepted beat latches beats_left = wr_burstcount − 1. Each later accepted beat decrements it.
  - The accepted beat with beats_left = 0 (including a burstcount = 1 first beat) → IDLE.
- burstcount 0 is treated as 1.
- avm_readdatavalid in any state other than RD_DATA is discarded; rd_readdatavalid = 0.
- starve_cnt (8-bit, saturating):
  - Increments each cycle wr_write = 1 while grant[0] = 0.
  - Clears on entry to WR_DATA.

## Timing
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N gets grant and the avm_* strobe valid in cycle N+1.
- There is one mandatory IDLE cycle between consecutive bursts.
- Master stall is passthrough (zero added latency) while granted.
- A write burst of B beats with no slave stall occupies B cycles after grant.
- A read burst occupies 1 command cycle plus the slave latency plus B data cycles.
- Reset values:
  - grant = 00, state = IDLE.
  - avm_read/avm_write = 0; avm_address, avm_burstcount, avm_byteenable, avm_writedata = 0.
  - wr_waitrequest = rd_waitrequest = 1.
  - rd_readdatavalid = 0, beats_left = 0, starve_cnt = 0, statistics counters = 0.
- Reset asserted mid-burst:
  - The FSM returns to IDLE at the next edge.
  - Outstanding slave read beats after reset are dropped.
- A request deasserted while in IDLE is never granted; there is no memory of past requests.

## Configuration
- ARB_STATS_EN defined: adds outputs stat_rd_bursts and stat_wr_bursts (16 bits each, saturating at 0xFFFF).
  - stat_rd_bursts increments on entry to RD_CMD.
  - stat_wr_bursts increments on entry to WR_DATA.
  - Both clear on reset.
- ARB_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single read: rd_read, burstcount 16, address 0x308DDC00; slave waitrequest 2 cycles, then 16 valid beats.
  - Required: one avm_read accept at that address.
  - Required: 16 rd_readdatavalid pulses.
  - Required: grant returns to 00 the cycle after beat 16.
- Single write: wr_write with burstcount 16, zero stall.
  - Required: 16 consecutive avm_write beats.
  - Required: rd_waitrequest = 1 throughout.
  - Required: IDLE one cycle after the last beat.
- Contention: rd_read and wr_write both held continuously, 4-beat bursts.
  - Required: reads win until starve_cnt reaches 64.
  - Required: the next grant is write and starve_cnt returns to 0.
- Stray data: avm_readdatavalid pulsed during IDLE and during WR_DATA.
  - Required: rd_readdatavalid stays 0 and beats_left is unchanged.
- Reset mid-RD_DATA after beat 5 of 16.
  - Required: the next edge shows IDLE, grant 00, rd_waitrequest 1.
  - Required: the remaining beats are ignored.
- With ARB_STATS_EN: 3 read bursts and 2 write bursts.
  - Required: stat_rd_bursts = 3 and stat_wr_bursts = 2.
